// File: rtl/fifo_stream_reader_if.sv
// fifo_stream_reader_if
//   Bundles the FIFO read port and the packed output stream of
//   fifo_stream_reader.
//   fifo_rd_en  : pop request to the FIFO (driven by the reader)
//   fifo_dout   : show-ahead FIFO head word, valid while fifo_empty=0
//   fifo_empty  : FIFO empty flag
//   out_valid   : packed beat valid
//   out_ready   : downstream accepts the beat
//   out_data    : packed beat, first-popped word in the low lane
//   out_last    : beat closes a frame
//   frame_done  : one-cycle pulse after the closing beat is accepted
//   Valid/ready: a beat transfers on a rising edge where out_valid and
//   out_ready are both 1; while out_valid=1 and out_ready=0 the beat
//   (out_data, out_last) holds stable and out_valid stays high.
//   Modport master is the reader; slave is the FIFO plus downstream side.
interface fifo_stream_reader_if #(
    parameter int DATA_WIDTH = 16,
    parameter int PACK       = 2
);
    logic                       fifo_rd_en;
    logic [DATA_WIDTH-1:0]      fifo_dout;
    logic                       fifo_empty;
    logic                       out_valid;
    logic                       out_ready;
    logic [DATA_WIDTH*PACK-1:0] out_data;
    logic                       out_last;
    logic                       frame_done;

    modport master (
        output fifo_rd_en,
        input  fifo_dout,
        input  fifo_empty,
        output out_valid,
        input  out_ready,
        output out_data,
        output out_last,
        output frame_done
    );

    modport slave (
        input  fifo_rd_en,
        output fifo_dout,
        output fifo_empty,
        input  out_valid,
        output out_ready,
        input  out_data,
        input  out_last,
        input  frame_done
    );
endinterface

// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader
//   Drains a show-ahead FIFO and packs PACK consecutive words into one
//   output beat; every FRAME_WORDS words the closing beat carries out_last
//   and frame_done pulses the cycle after that beat is accepted.
//   Ports:
//     clk     : clock, rising edge
//     reset_n : asynchronous active-low reset
//     bus     : fifo_stream_reader_if.master (FIFO read port + output stream)
//   The interface instance must use the same DATA_WIDTH and PACK values.
module fifo_stream_reader #(
    parameter int DATA_WIDTH  = 16,
    parameter int PACK        = 2,
    parameter int FRAME_WORDS = 1024
) (
    input  logic                 clk,
    input  logic                 reset_n,
    fifo_stream_reader_if.master bus
);
    localparam int BEATS     = FRAME_WORDS / PACK;
    localparam int LANE_W    = (PACK > 1) ? $clog2(PACK) : 1;
    localparam int BEAT_W    = (BEATS > 1) ? $clog2(BEATS) : 1;
    // PACK=1 needs no assembly lanes; keep one dummy lane so the array is legal.
    localparam int ASM_LANES = (PACK > 1) ? PACK - 1 : 1;
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(PACK - 1);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

    logic [LANE_W-1:0]          lane_q;
    logic [DATA_WIDTH-1:0]      asm_q [ASM_LANES];
    logic [BEAT_W-1:0]          beat_q;
    logic [DATA_WIDTH*PACK-1:0] data_q;
    logic                       valid_q;
    logic                       last_q;
    logic                       done_q;

    logic                       at_last_lane;
    logic                       pop;
    logic                       load;
    logic                       accept;
    logic [BEAT_W-1:0]          next_beat;
    logic [BEAT_W-1:0]          load_beat;
    logic [DATA_WIDTH*PACK-1:0] beat_data;

    assign at_last_lane = (lane_q == LAST_LANE);
    // The final lane may only be popped when the output register is free
    // or is being emptied on this same edge.
    assign pop    = reset_n && !bus.fifo_empty &&
                    (!at_last_lane || !valid_q || bus.out_ready);
    assign load   = pop && at_last_lane;
    assign accept = valid_q && bus.out_ready;

    assign next_beat = (beat_q == LAST_BEAT) ? '0 : beat_q + 1'b1;
    // beat_q numbers the oldest unaccepted beat; if that beat leaves on the
    // edge where a new one loads, the new one is its successor.
    assign load_beat = accept ? next_beat : beat_q;

    always_comb begin
        beat_data = '0;
        for (int i = 0; i < PACK - 1; i++) begin
            beat_data[i*DATA_WIDTH +: DATA_WIDTH] = asm_q[i];
        end
        beat_data[(PACK-1)*DATA_WIDTH +: DATA_WIDTH] = bus.fifo_dout;
    end

    // Lane counter and assembly lanes
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lane_q <= '0;
            for (int i = 0; i < ASM_LANES; i++) begin
                asm_q[i] <= '0;
            end
        end else if (pop) begin
            if (at_last_lane) begin
                lane_q <= '0;
            end else begin
                lane_q <= lane_q + 1'b1;
                for (int i = 0; i < ASM_LANES; i++) begin
                    if (lane_q == LANE_W'(i)) begin
                        asm_q[i] <= bus.fifo_dout;
                    end
                end
            end
        end
    end

    // Output register, beat counter and frame pulse
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            beat_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= accept && last_q;
            if (accept) begin
                beat_q <= next_beat;
            end
            if (load) begin
                data_q  <= beat_data;
                valid_q <= 1'b1;
                last_q  <= (load_beat == LAST_BEAT);
            end else if (accept) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign bus.fifo_rd_en = pop;
    assign bus.out_valid  = valid_q;
    assign bus.out_data   = data_q;
    assign bus.out_last   = last_q;
    assign bus.frame_done = done_q;
endmodule

// File: tb/tb_fifo_stream_reader.sv
// tb_fifo_stream_reader
//   Directed bench for fifo_stream_reader with DATA_WIDTH=16, PACK=2,
//   FRAME_WORDS=8. A small show-ahead FIFO model feeds the reader; a
//   monitor records every accepted beat and every frame_done pulse.
module tb_fifo_stream_reader;
    localparam int DW = 16;
    localparam int PK = 2;
    localparam int FW = 8;

    // ---------------- clock / reset ----------------
    logic clk     = 1'b0;
    logic reset_n = 1'b1;
    always #5 clk = ~clk;

    fifo_stream_reader_if #(.DATA_WIDTH(DW), .PACK(PK)) bus ();

    fifo_stream_reader #(
        .DATA_WIDTH (DW),
        .PACK       (PK),
        .FRAME_WORDS(FW)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    // ---------------- FIFO model ----------------
    logic [DW-1:0] mem [64];
    int   wr_ptr     = 0;
    int   rd_ptr     = 0;
    int   pop_cnt    = 0;
    int   empty_pops = 0;
    logic gate_empty = 1'b0;
    logic bubble_en  = 1'b0;
    logic out_ready  = 1'b0;

    assign bus.fifo_empty = gate_empty || (rd_ptr == wr_ptr);
    assign bus.fifo_dout  = mem[rd_ptr[5:0]];
    assign bus.out_ready  = out_ready;

    always @(posedge clk) begin
        if (bus.fifo_rd_en && !bus.fifo_empty) begin
            rd_ptr  <= rd_ptr + 1;
            pop_cnt <= pop_cnt + 1;
        end
        if (bus.fifo_rd_en && bus.fifo_empty) empty_pops <= empty_pops + 1;
    end

    always @(negedge clk) gate_empty <= bubble_en ? !gate_empty : 1'b0;

    // ---------------- monitor ----------------
    int                cyc = 0;
    logic [DW*PK-1:0]  cap_data [$];
    logic              cap_last [$];
    int                acc_last_cyc [$];
    int                fd_cyc [$];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bus.out_valid && bus.out_ready) begin
            cap_data.push_back(bus.out_data);
            cap_last.push_back(bus.out_last);
            if (bus.out_last) acc_last_cyc.push_back(cyc);
        end
        if (bus.frame_done) fd_cyc.push_back(cyc);
    end

    // ---------------- scoreboard state ----------------
    int n_checks = 0;
    int n_pass   = 0;
    logic [DW*PK-1:0] exp_q [$];
    logic             exp_last_q [$];

    // ---------------- driver tasks ----------------
    task automatic push_word(input logic [DW-1:0] w);
        mem[wr_ptr[5:0]] = w;
        wr_ptr = wr_ptr + 1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n   = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic wait_beats(input int target, input int budget, output int used);
        used = 0;
        while (cap_data.size() < target && used < budget) begin
            @(negedge clk);
            used++;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        #1 reset_n = 1'b0;
        @(negedge clk);
        out_ready = 1'b1;
        push_word(16'h0001);
        push_word(16'h0002);
        @(negedge clk);
        n_checks++; if (bus.fifo_rd_en !== 1'b0) $display("FAIL reset_rd_en got=%b exp=0", bus.fifo_rd_en); else n_pass++;
        n_checks++; if (bus.out_valid !== 1'b0) $display("FAIL reset_valid got=%b exp=0", bus.out_valid); else n_pass++;
        n_checks++; if (bus.out_data !== '0) $display("FAIL reset_data got=%h exp=0", bus.out_data); else n_pass++;
        n_checks++; if (bus.out_last !== 1'b0) $display("FAIL reset_last got=%b exp=0", bus.out_last); else n_pass++;
        n_checks++; if (bus.frame_done !== 1'b0) $display("FAIL reset_frame_done got=%b exp=0", bus.frame_done); else n_pass++;
        n_checks++; if (pop_cnt !== 0) $display("FAIL reset_no_pop got=%0d exp=0", pop_cnt); else n_pass++;
        reset_n = 1'b1;
        #1;
        n_checks++; if (bus.fifo_rd_en !== 1'b1) $display("FAIL release_rd_en got=%b exp=1", bus.fifo_rd_en); else n_pass++;
    endtask

    task automatic test_packing();
        // continues straight from the reset release with 0x0001, 0x0002 queued
        @(negedge clk);
        n_checks++; if (pop_cnt !== 1) $display("FAIL pack_pop1 got=%0d exp=1", pop_cnt); else n_pass++;
        n_checks++; if (bus.out_valid !== 1'b0) $display("FAIL pack_valid_early got=%b exp=0", bus.out_valid); else n_pass++;
        @(negedge clk);
        n_checks++; if (pop_cnt !== 2) $display("FAIL pack_pop2 got=%0d exp=2", pop_cnt); else n_pass++;
        n_checks++; if (bus.out_valid !== 1'b1) $display("FAIL pack_valid got=%b exp=1", bus.out_valid); else n_pass++;
        n_checks++; if (bus.out_data !== 32'h0002_0001) $display("FAIL pack_data got=%h exp=00020001", bus.out_data); else n_pass++;
        n_checks++; if (bus.out_last !== 1'b0) $display("FAIL pack_last got=%b exp=0", bus.out_last); else n_pass++;
        @(negedge clk);
        n_checks++; if (bus.out_valid !== 1'b0) $display("FAIL pack_valid_drop got=%b exp=0", bus.out_valid); else n_pass++;
        n_checks++; if (bus.fifo_rd_en !== 1'b0) $display("FAIL pack_rd_en_empty got=%b exp=0", bus.fifo_rd_en); else n_pass++;
    endtask

    task automatic test_backpressure();
        int p0;
        int n0;
        do_reset();
        p0 = pop_cnt;
        n0 = cap_data.size();
        push_word(16'h000A);
        push_word(16'h000B);
        push_word(16'h000C);
        push_word(16'h000D);
        repeat (3) @(negedge clk);
        n_checks++; if (pop_cnt - p0 !== 3) $display("FAIL bp_pops_stall got=%0d exp=3", pop_cnt - p0); else n_pass++;
        n_checks++; if (bus.out_valid !== 1'b1) $display("FAIL bp_valid got=%b exp=1", bus.out_valid); else n_pass++;
        n_checks++; if (bus.out_data !== 32'h000B_000A) $display("FAIL bp_data got=%h exp=000b000a", bus.out_data); else n_pass++;
        n_checks++; if (bus.fifo_empty !== 1'b0) $display("FAIL bp_fifo_nonempty got=%b exp=0", bus.fifo_empty); else n_pass++;
        n_checks++; if (bus.fifo_rd_en !== 1'b0) $display("FAIL bp_rd_en_held got=%b exp=0", bus.fifo_rd_en); else n_pass++;
        @(negedge clk);
        n_checks++; if (bus.out_data !== 32'h000B_000A) $display("FAIL bp_data_hold got=%h exp=000b000a", bus.out_data); else n_pass++;
        n_checks++; if (pop_cnt - p0 !== 3) $display("FAIL bp_pops_hold got=%0d exp=3", pop_cnt - p0); else n_pass++;
        out_ready = 1'b1;
        #1;
        n_checks++; if (bus.fifo_rd_en !== 1'b1) $display("FAIL bp_rd_en_release got=%b exp=1", bus.fifo_rd_en); else n_pass++;
        @(negedge clk);
        n_checks++; if (pop_cnt - p0 !== 4) $display("FAIL bp_pops_after got=%0d exp=4", pop_cnt - p0); else n_pass++;
        n_checks++; if (bus.out_valid !== 1'b1) $display("FAIL bp_valid_replace got=%b exp=1", bus.out_valid); else n_pass++;
        n_checks++; if (bus.out_data !== 32'h000D_000C) $display("FAIL bp_data2 got=%h exp=000d000c", bus.out_data); else n_pass++;
        @(negedge clk);
        n_checks++; if (bus.out_valid !== 1'b0) $display("FAIL bp_valid_end got=%b exp=0", bus.out_valid); else n_pass++;
        n_checks++; if (cap_data.size() - n0 !== 2) $display("FAIL bp_beat_count got=%0d exp=2", cap_data.size() - n0); else n_pass++;
    endtask

    task automatic test_framing();
        int n0;
        int a0;
        int f0;
        int used;
        do_reset();
        out_ready = 1'b1;
        n0 = cap_data.size();
        a0 = acc_last_cyc.size();
        f0 = fd_cyc.size();
        exp_q.delete();
        exp_last_q.delete();
        for (int k = 0; k < 8; k++) begin
            exp_q.push_back({16'(2 * k + 2), 16'(2 * k + 1)});
            exp_last_q.push_back(k == 3 || k == 7);
        end
        for (int w = 1; w <= 16; w++) push_word(16'(w));
        wait_beats(n0 + 8, 60, used);
        n_checks++; if (used !== 17) $display("FAIL frame_throughput got=%0d cycles exp=17", used); else n_pass++;
        repeat (3) @(negedge clk);
        for (int k = 0; k < 8; k++) begin
            if (n0 + k < cap_data.size()) begin
                n_checks++; if (cap_data[n0 + k] !== exp_q[k]) $display("FAIL frame_data beat=%0d got=%h exp=%h", k, cap_data[n0 + k], exp_q[k]); else n_pass++;
                n_checks++; if (cap_last[n0 + k] !== exp_last_q[k]) $display("FAIL frame_last beat=%0d got=%b exp=%b", k, cap_last[n0 + k], exp_last_q[k]); else n_pass++;
            end else begin
                n_checks++; $display("FAIL frame_missing beat=%0d got=none exp=%h", k, exp_q[k]);
            end
        end
        n_checks++; if (fd_cyc.size() - f0 !== 2) $display("FAIL frame_done_count got=%0d exp=2", fd_cyc.size() - f0); else n_pass++;
        if (fd_cyc.size() - f0 == 2 && acc_last_cyc.size() - a0 == 2) begin
            for (int i = 0; i < 2; i++) begin
                n_checks++; if (fd_cyc[f0 + i] !== acc_last_cyc[a0 + i] + 1) $display("FAIL frame_done_timing idx=%0d got=%0d exp=%0d", i, fd_cyc[f0 + i], acc_last_cyc[a0 + i] + 1); else n_pass++;
            end
        end else begin
            n_checks++; $display("FAIL frame_done_pairs got=%0d/%0d exp=2/2", fd_cyc.size() - f0, acc_last_cyc.size() - a0);
        end
    endtask

    task automatic test_bubbles();
        int n0;
        int p0;
        int used;
        do_reset();
        out_ready = 1'b1;
        n0 = cap_data.size();
        p0 = pop_cnt;
        exp_q.delete();
        exp_q.push_back(32'h0002_0001);
        exp_q.push_back(32'h0004_0003);
        exp_q.push_back(32'h0006_0005);
        bubble_en = 1'b1;
        for (int w = 1; w <= 6; w++) push_word(16'(w));
        wait_beats(n0 + 3, 60, used);
        bubble_en = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++; if (used >= 60) $display("FAIL bubble_timeout got=%0d beats exp=3", cap_data.size() - n0); else n_pass++;
        n_checks++; if (pop_cnt - p0 !== 6) $display("FAIL bubble_pops got=%0d exp=6", pop_cnt - p0); else n_pass++;
        for (int k = 0; k < 3; k++) begin
            if (n0 + k < cap_data.size()) begin
                n_checks++; if (cap_data[n0 + k] !== exp_q[k]) $display("FAIL bubble_data beat=%0d got=%h exp=%h", k, cap_data[n0 + k], exp_q[k]); else n_pass++;
            end
        end
        n_checks++; if (empty_pops !== 0) $display("FAIL bubble_pop_when_empty got=%0d exp=0", empty_pops); else n_pass++;
    endtask

    task automatic test_midframe_reset();
        int n0;
        int p0;
        int used;
        do_reset();
        out_ready = 1'b1;
        p0 = pop_cnt;
        push_word(16'h0001);
        push_word(16'h0002);
        push_word(16'h0003);
        repeat (4) @(negedge clk);
        n_checks++; if (pop_cnt - p0 !== 3) $display("FAIL mid_pops got=%0d exp=3", pop_cnt - p0); else n_pass++;
        reset_n = 1'b0;
        #1;
        n_checks++; if (bus.out_valid !== 1'b0) $display("FAIL mid_valid got=%b exp=0", bus.out_valid); else n_pass++;
        n_checks++; if (bus.out_data !== '0) $display("FAIL mid_data got=%h exp=0", bus.out_data); else n_pass++;
        n_checks++; if (bus.out_last !== 1'b0) $display("FAIL mid_last got=%b exp=0", bus.out_last); else n_pass++;
        n_checks++; if (bus.fifo_rd_en !== 1'b0) $display("FAIL mid_rd_en got=%b exp=0", bus.fifo_rd_en); else n_pass++;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        n0 = cap_data.size();
        exp_q.delete();
        exp_last_q.delete();
        for (int k = 0; k < 4; k++) begin
            exp_q.push_back({16'(8'h12 + 2 * k), 16'(8'h11 + 2 * k)});
            exp_last_q.push_back(k == 3);
        end
        for (int w = 0; w < 8; w++) push_word(16'(8'h11 + w));
        wait_beats(n0 + 4, 40, used);
        n_checks++; if (used >= 40) $display("FAIL mid_timeout got=%0d beats exp=4", cap_data.size() - n0); else n_pass++;
        for (int k = 0; k < 4; k++) begin
            if (n0 + k < cap_data.size()) begin
                n_checks++; if (cap_data[n0 + k] !== exp_q[k]) $display("FAIL mid_data beat=%0d got=%h exp=%h", k, cap_data[n0 + k], exp_q[k]); else n_pass++;
                n_checks++; if (cap_last[n0 + k] !== exp_last_q[k]) $display("FAIL mid_last beat=%0d got=%b exp=%b", k, cap_last[n0 + k], exp_last_q[k]); else n_pass++;
            end
        end
        repeat (2) @(negedge clk);
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        test_reset();
        test_packing();
        test_backpressure();
        test_framing();
        test_bubbles();
        test_midframe_reset();
        n_checks++; if (empty_pops !== 0) $display("FAIL final_pop_when_empty got=%0d exp=0", empty_pops); else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end
endmodule
